// File: rtl/alu_operand_regfile_pkg.sv
// Shared definitions for the ALU operand-issue stage and the ALU itself:
// datapath defaults and the 3-bit command encoding.
package alu_operand_regfile_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_AW    = 5;
    localparam int ALU_NREGS = 32;

    typedef enum logic [2:0] {
        CMD_ADD  = 3'd0,
        CMD_SUB  = 3'd1,
        CMD_SLT  = 3'd2,
        CMD_XOR  = 3'd3,
        CMD_NAND = 3'd4,
        CMD_AND  = 3'd5,
        CMD_NOR  = 3'd6,
        CMD_OR   = 3'd7
    } alu_cmd_e;

endpackage

// File: rtl/alu_operand_regfile_regfile_bank.sv
// General register storage: one write port, two combinational read ports.
// Register 0 is never written and always reads as zero.
module regfile_bank
    import alu_operand_regfile_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int NREGS = ALU_NREGS,
    parameter int AW    = ALU_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_a_addr_i,
    output logic [WIDTH-1:0] rd_a_data_o,
    input  logic [AW-1:0]    rd_b_addr_i,
    output logic [WIDTH-1:0] rd_b_data_o
);

    logic [WIDTH-1:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i && (wr_addr_i != '0)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Entry 0 is also cleared at reset, but forcing the read keeps r0 correct
    // even if a future change lets a write slip through.
    always_comb begin
        rd_a_data_o = '0;
        rd_b_data_o = '0;
        if (rd_a_addr_i != '0) rd_a_data_o = mem_q[rd_a_addr_i];
        if (rd_b_addr_i != '0) rd_b_data_o = mem_q[rd_b_addr_i];
    end

endmodule

// File: rtl/alu_operand_regfile.sv
// Operand-issue stage: register file read with write-to-read bypass, feeding
// registered operandA/operandB/command to the ALU one cycle after issue.
module alu_operand_regfile
    import alu_operand_regfile_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int NREGS = ALU_NREGS,
    parameter int AW    = ALU_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    input  logic [2:0]       cmd_in,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] operandA,
    output logic [WIDTH-1:0] operandB,
    output logic [2:0]       command,
    output logic             op_valid
);

    // Valid semantics: op_valid is high for exactly one cycle per issue, the
    // cycle after it; there is no ready, the ALU always accepts the operands.
    logic [WIDTH-1:0] bank_a, bank_b;
    logic [WIDTH-1:0] operand_a_d, operand_b_d;
    logic [WIDTH-1:0] operand_a_q, operand_b_q;
    logic [2:0]       command_d, command_q;
    logic             op_valid_d, op_valid_q;

    regfile_bank #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .rd_a_addr_i (ra),
        .rd_a_data_o (bank_a),
        .rd_b_addr_i (rb),
        .rd_b_data_o (bank_b)
    );

    // A same-cycle write to the read register wins over stored contents;
    // r0 is excluded so a dropped write to r0 can never leak through.
    always_comb begin
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        command_d   = command_q;
        op_valid_d  = 1'b0;
        if (issue) begin
            operand_a_d = (wr_en && (wr_addr == ra) && (ra != '0)) ? wr_data : bank_a;
            operand_b_d = (wr_en && (wr_addr == rb) && (rb != '0)) ? wr_data : bank_b;
            command_d   = cmd_in;
            op_valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand_a_q <= '0;
            operand_b_q <= '0;
            command_q   <= CMD_ADD;
            op_valid_q  <= 1'b0;
        end else begin
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            command_q   <= command_d;
            op_valid_q  <= op_valid_d;
        end
    end

    assign operandA = operand_a_q;
    assign operandB = operand_b_q;
    assign command  = command_q;
    assign op_valid = op_valid_q;

endmodule
